// File: rtl/mips_pkg.sv
// mips_pkg: shared CPU constants for fetch FSM encoding, reset PC and word alignment
package mips_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [1:0] WORD_MASK = 2'b11;
  function automatic logic is_aligned(input logic [31:0] a);
    return (a[1:0] & WORD_MASK) == 2'b00;
  endfunction
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts consecutive wait cycles of an instruction fetch
//   clk, rst (async active-low); clear zeroes the count, enable advances it;
//   expired is high while enabled in the last permitted wait cycle.
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [7:0] count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= 8'd0;
    else count <= clear ? 8'd0 : enable ? count + 8'd1 : count;
  assign expired = enable && count == 8'(TIMEOUT - 1);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with PC, memory handshake and timeout
//   clk, rst (async active-low); fetch_start, npc/npc_wr from control/branch logic;
//   im_req/im_addr/im_ack/im_dout memory port; instr/irwr to IR; pc, busy, fetch_err status.
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic [31:0] npc,
  input  logic        npc_wr,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_dout,
  output logic [31:0] instr,
  output logic        irwr,
  output logic [31:0] pc,
  output logic        busy,
  output logic        fetch_err
);
  logic [1:0] state;
  logic start_ok, expired;
  assign start_ok = state == S_IDLE && fetch_start && is_aligned(pc);
  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(start_ok),
    .enable(state == S_REQ && !im_ack),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      im_addr <= 32'd0;
      instr <= 32'd0;
      im_req <= 1'b0;
      irwr <= 1'b0;
      busy <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      irwr <= 1'b0;
      // a branch/jump target overrides the sequential advance
      pc <= npc_wr ? npc : state == S_DONE ? pc + 32'd4 : pc;
      if (state == S_IDLE && fetch_start) begin
        if (start_ok) begin
          state <= S_REQ;
          im_req <= 1'b1;
          im_addr <= pc;
          busy <= 1'b1;
          fetch_err <= 1'b0;
        end else fetch_err <= 1'b1;
      end else if (state == S_REQ && im_ack) begin
        state <= S_DONE;
        instr <= im_dout;
        im_req <= 1'b0;
        irwr <= 1'b1;
      end else if (state == S_REQ && expired) begin
        state <= S_IDLE;
        im_req <= 1'b0;
        busy <= 1'b0;
        fetch_err <= 1'b1;
      end else if (state == S_DONE) begin
        state <= S_IDLE;
        busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic fetch_start = 1'b0, npc_wr = 1'b0, im_ack = 1'b0;
  logic [31:0] npc = 32'd0, im_dout = 32'd0;
  logic im_req, irwr, busy, fetch_err;
  logic [31:0] im_addr, instr, pc;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  fetch_ctrl #(.RESET_PC(32'h0000_3000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .npc(npc), .npc_wr(npc_wr),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_dout(im_dout),
    .instr(instr), .irwr(irwr), .pc(pc), .busy(busy), .fetch_err(fetch_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".pc"}, pc, 32'h3000);
    chk({tag, ".im_req"}, 32'(im_req), 0);
    chk({tag, ".im_addr"}, im_addr, 0);
    chk({tag, ".instr"}, instr, 0);
    chk({tag, ".irwr"}, 32'(irwr), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".err"}, 32'(fetch_err), 0);
  endtask
  initial begin
    #12;
    chk_reset("rst");
    tick;
    rst = 1'b1;
    tick;
    chk("post_rst.pc", pc, 32'h3000);
    // zero-wait fetch
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    chk("f0.im_req", 32'(im_req), 1);
    chk("f0.im_addr", im_addr, 32'h3000);
    chk("f0.busy", 32'(busy), 1);
    chk("f0.irwr", 32'(irwr), 0);
    im_ack = 1'b1;
    im_dout = 32'h2408_0005;
    tick;
    im_ack = 1'b0;
    chk("f0.irwr_pulse", 32'(irwr), 1);
    chk("f0.instr", instr, 32'h2408_0005);
    chk("f0.req_drop", 32'(im_req), 0);
    chk("f0.pc_hold", pc, 32'h3000);
    tick;
    chk("f0.irwr_end", 32'(irwr), 0);
    chk("f0.pc", pc, 32'h3004);
    chk("f0.busy_end", 32'(busy), 0);
    // ack delayed 5 cycles
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("f1.wait_req", 32'(im_req), 1);
      chk("f1.wait_addr", im_addr, 32'h3004);
      chk("f1.wait_irwr", 32'(irwr), 0);
      tick;
    end
    im_ack = 1'b1;
    im_dout = 32'hDEAD_BEEF;
    tick;
    im_ack = 1'b0;
    chk("f1.irwr", 32'(irwr), 1);
    chk("f1.instr", instr, 32'hDEAD_BEEF);
    tick;
    chk("f1.irwr_end", 32'(irwr), 0);
    chk("f1.pc", pc, 32'h3008);
    tick;
    chk("f1.pc_once", pc, 32'h3008);
    chk("f1.irwr_once", 32'(irwr), 0);
    // no ack -> timeout after 16 request cycles
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to.req_held", 32'(im_req), 1);
      chk("to.no_irwr", 32'(irwr), 0);
      tick;
    end
    chk("to.req_drop", 32'(im_req), 0);
    chk("to.err", 32'(fetch_err), 1);
    chk("to.irwr", 32'(irwr), 0);
    chk("to.busy", 32'(busy), 0);
    chk("to.pc", pc, 32'h3008);
    chk("to.instr", instr, 32'hDEAD_BEEF);
    im_ack = 1'b1;
    tick;
    im_ack = 1'b0;
    chk("stray_ack.irwr", 32'(irwr), 0);
    chk("stray_ack.req", 32'(im_req), 0);
    chk("err_sticky", 32'(fetch_err), 1);
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    chk("err_clear", 32'(fetch_err), 0);
    chk("refetch.req", 32'(im_req), 1);
    im_ack = 1'b1;
    im_dout = 32'h1111_1111;
    tick;
    im_ack = 1'b0;
    tick;
    chk("refetch.pc", pc, 32'h300C);
    // misaligned pc
    npc = 32'h0000_3002;
    npc_wr = 1'b1;
    tick;
    npc_wr = 1'b0;
    chk("mis.pc", pc, 32'h3002);
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    chk("mis.err", 32'(fetch_err), 1);
    chk("mis.req", 32'(im_req), 0);
    chk("mis.busy", 32'(busy), 0);
    tick;
    chk("mis.req_later", 32'(im_req), 0);
    // npc_wr in DONE overrides the increment
    npc = 32'h0000_3200;
    npc_wr = 1'b1;
    tick;
    npc_wr = 1'b0;
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    chk("nd.addr", im_addr, 32'h3200);
    im_ack = 1'b1;
    im_dout = 32'h0C00_0C00;
    tick;
    im_ack = 1'b0;
    chk("nd.irwr", 32'(irwr), 1);
    npc = 32'h0000_3100;
    npc_wr = 1'b1;
    tick;
    npc_wr = 1'b0;
    chk("nd.pc", pc, 32'h3100);
    chk("nd.err", 32'(fetch_err), 0);
    // wrap at top of address space
    npc = 32'hFFFF_FFFC;
    npc_wr = 1'b1;
    tick;
    npc_wr = 1'b0;
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    chk("wrap.addr", im_addr, 32'hFFFF_FFFC);
    im_ack = 1'b1;
    tick;
    im_ack = 1'b0;
    tick;
    chk("wrap.pc", pc, 32'h0);
    // async reset in the middle of a request
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    chk("mr.req", 32'(im_req), 1);
    #2 rst = 1'b0;
    #1;
    chk_reset("mr");
    tick;
    rst = 1'b1;
    im_ack = 1'b1;
    im_dout = 32'h5555_AAAA;
    tick;
    im_ack = 1'b0;
    chk("late_ack.irwr", 32'(irwr), 0);
    chk("late_ack.instr", instr, 0);
    chk("late_ack.req", 32'(im_req), 0);
    chk("late_ack.busy", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
